// File: rtl/ltl_report_arbiter_if.sv
// Report stream between the arbiter's output FIFO and the report/interrupt
// logic. The producer presents the head entry and the consumer acknowledges it.
interface ltl_report_arbiter_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [IDX_W-1:0] rpt_id;
  logic [CNT_W-1:0] rpt_cycle;

  modport master (output rpt_valid, rpt_id, rpt_cycle, input rpt_ready);
  modport slave  (input rpt_valid, rpt_id, rpt_cycle, output rpt_ready);
endinterface

// File: rtl/ltl_report_arbiter.sv
// Serialises the report wires of one monitor stage into a stream of
// {report index, symbol stamp} entries. A multi-report symbol is captured
// once, then drained lowest index first at one entry per cycle. hold stops
// the feeder while a drain is in progress or the FIFO is nearly full.
module ltl_report_arbiter #(
  parameter int NUM_REPORTS = 40,
  parameter int IDX_W       = 6,
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_in,
  input  logic                   clr_overflow,
  output logic                   hold,
  output logic                   overflow,
  output logic [CNT_W-1:0]       sym_cnt,
  ltl_report_arbiter_if.master   rpt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = IDX_W + CNT_W;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REPORTS-1:0] pend_q, pend_d;
  logic [NUM_REPORTS-1:0] low_bit;
  logic [IDX_W-1:0]       low_idx;
  logic [CNT_W-1:0]       stamp_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [FCW-1:0]         fcount;
  logic                   push, pop, push_ok, capture;
  logic [IDX_W-1:0]       head_id;
  logic [CNT_W-1:0]       head_cycle;

  // Index of the lowest set bit; only called with a nonzero vector in DRAIN.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REPORTS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // Isolate the lowest pending bit so it can be cleared without a decoder.
  assign low_bit = pend_q & (~pend_q + NUM_REPORTS'(1));
  assign low_idx = lowest_idx(pend_q);

  assign pop     = (fcount != '0) && rpt.rpt_ready;
  assign push_ok = (fcount < FCW'(FIFO_DEPTH)) || pop;

  // Decoded from registered state only, so the feeder sees no input-to-output path.
  assign hold = (state_q == DRAIN) || (fcount >= FCW'(FIFO_DEPTH - 1));

  // Next-state and drain control.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    push    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // A report arriving while hold is up is a protocol violation and is dropped.
        if (run && (|report_in) && !hold) begin
          capture = 1'b1;
          pend_d  = report_in;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (push_ok) begin
          push   = 1'b1;
          pend_d = pend_q & ~low_bit;
          if ((pend_q & ~low_bit) == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, pending mask, FIFO pointers, counters and sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fcount  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fcount <= fcount + FCW'(1);
        2'b01:   fcount <= fcount - FCW'(1);
        default: fcount <= fcount;
      endcase
      if (run) cnt_q <= cnt_q + CNT_W'(1);
      // Set takes priority over a clear in the same cycle.
      if (run && hold && (|report_in)) ovf_q <= 1'b1;
      else if (clr_overflow)           ovf_q <= 1'b0;
    end
  end

  // Datapath storage: capture stamp and FIFO entries; contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (capture) stamp_q <= cnt_q;
    if (push)    mem[wr_ptr] <= {low_idx, stamp_q};
  end

  assign {head_id, head_cycle} = mem[rd_ptr];

  // Head fields read as zero when empty so outputs are defined straight out of reset.
  assign rpt.rpt_valid = (fcount != '0);
  assign rpt.rpt_id    = rpt.rpt_valid ? head_id    : '0;
  assign rpt.rpt_cycle = rpt.rpt_valid ? head_cycle : '0;
  assign overflow      = ovf_q;
  assign sym_cnt       = cnt_q;

endmodule

// File: tb/tb_ltl_report_arbiter.sv
// Bench for ltl_report_arbiter: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ltl_report_arbiter;
  localparam int NR    = 40;
  localparam int IW    = 6;
  localparam int CW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          ready = 1'b0;
  logic [NR-1:0] report_in = '0;
  logic          hold, overflow;
  logic [CW-1:0] sym_cnt;
  logic          hold_w, ovf_w;
  logic [3:0]    cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltl_report_arbiter_if #(.IDX_W(IW), .CNT_W(CW)) rif ();
  ltl_report_arbiter_if #(.IDX_W(IW), .CNT_W(4))  wif ();
  assign rif.rpt_ready = ready;
  assign wif.rpt_ready = 1'b1;

  ltl_report_arbiter #(.NUM_REPORTS(NR), .IDX_W(IW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .report_in(report_in),
    .clr_overflow(clr_overflow), .hold(hold), .overflow(overflow),
    .sym_cnt(sym_cnt), .rpt(rif)
  );

  ltl_report_arbiter #(.NUM_REPORTS(NR), .IDX_W(IW), .CNT_W(4), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(reset), .run(run), .report_in(report_in),
    .clr_overflow(clr_overflow), .hold(hold_w), .overflow(ovf_w),
    .sym_cnt(cnt_w), .rpt(wif)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a pending mask, a queue for the FIFO, plain counters.
  typedef struct packed {
    logic [IW-1:0] id;
    logic [CW-1:0] cyc;
  } ent_t;

  ent_t          mq[$];
  ent_t          e;
  logic [NR-1:0] m_pend = '0;
  logic [CW-1:0] m_stamp = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_ovf = 1'b0;
  bit            m_live = 0;
  bit            m_h, m_idle;
  int            m_lo;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_pend = '0;
      m_cnt  = '0;
      m_ovf  = 1'b0;
      m_live = 1;
    end else if (m_live) begin
      m_h    = (m_pend != '0) || (mq.size() >= DEPTH - 1);
      m_idle = (m_pend == '0);
      m_lo   = -1;
      for (int i = 0; i < NR; i++) if (m_pend[i] && m_lo < 0) m_lo = i;
      if (mq.size() != 0 && ready) void'(mq.pop_front());
      if (m_lo >= 0 && mq.size() < DEPTH) begin
        e.id  = IW'(m_lo);
        e.cyc = m_stamp;
        mq.push_back(e);
        m_pend[m_lo] = 1'b0;
      end
      if (m_idle && run && report_in != '0 && !m_h) begin
        m_pend  = report_in;
        m_stamp = m_cnt;
      end
      if (run && m_h && report_in != '0) m_ovf = 1'b1;
      else if (clr_overflow)             m_ovf = 1'b0;
      if (run) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_hold", hold, (m_pend != '0) || (mq.size() >= DEPTH - 1));
      chk("model_rpt_valid", rif.rpt_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("model_rpt_id", rif.rpt_id, mq[0].id);
        chk("model_rpt_cycle", rif.rpt_cycle, mq[0].cyc);
      end
      chk("model_overflow", overflow, m_ovf);
      chk("model_sym_cnt", sym_cnt, m_cnt);
    end
  end

  // Log of entries accepted by the consumer.
  logic [IW-1:0] log_q[$];
  always @(posedge clk) begin
    if (!reset && rif.rpt_valid && ready) log_q.push_back(rif.rpt_id);
  end

  task automatic drive(input logic r, input logic [NR-1:0] rep);
    @(posedge clk);
    #2;
    run       = r;
    report_in = rep;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1; run = 1'b0; report_in = '0; ready = 1'b0; clr_overflow = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    log_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Single report
    do_reset();
    chk("rst_hold", hold, 0);
    chk("rst_valid", rif.rpt_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_rpt_id", rif.rpt_id, 0);
    repeat (5) drive(1'b1, '0);
    drive(1'b1, NR'(1) << 9);
    drive(1'b0, '0);
    chk("t1_hold_on", hold, 1);
    chk("t1_valid_early", rif.rpt_valid, 0);
    chk("t1_sym_cnt", sym_cnt, 6);
    drive(1'b0, '0);
    chk("t1_hold_off", hold, 0);
    chk("t1_valid", rif.rpt_valid, 1);
    chk("t1_id", rif.rpt_id, 9);
    chk("t1_cycle", rif.rpt_cycle, 5);
    drive(1'b0, '0);
    chk("t1_id_stable", rif.rpt_id, 9);
    ready = 1'b1;
    drive(1'b0, '0);
    chk("t1_popped", rif.rpt_valid, 0);

    // Multi-report batch at sym_cnt 12
    do_reset();
    ready = 1'b1;
    repeat (12) drive(1'b1, '0);
    drive(1'b1, (NR'(1) << 0) | (NR'(1) << 4) | (NR'(1) << 39));
    drive(1'b0, '0);
    chk("t2_hold_c1", hold, 1);
    drive(1'b0, '0);
    chk("t2_hold_c2", hold, 1);
    chk("t2_id0", rif.rpt_id, 0);
    chk("t2_cyc0", rif.rpt_cycle, 12);
    drive(1'b0, '0);
    chk("t2_hold_c3", hold, 1);
    chk("t2_id1", rif.rpt_id, 4);
    drive(1'b0, '0);
    chk("t2_hold_end", hold, 0);
    chk("t2_id2", rif.rpt_id, 39);
    chk("t2_cyc2", rif.rpt_cycle, 12);
    drive(1'b0, '0);
    chk("t2_empty", rif.rpt_valid, 0);
    chk("t2_log_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t2_log0", log_q[0], 0);
      chk("t2_log1", log_q[1], 4);
      chk("t2_log2", log_q[2], 39);
    end

    // Backpressure with a 10-bit batch
    do_reset();
    drive(1'b1, NR'(10'h3FF));
    drive(1'b0, '0);
    repeat (10) drive(1'b0, '0);
    chk("t3_stall_hold", hold, 1);
    chk("t3_stall_valid", rif.rpt_valid, 1);
    chk("t3_stall_head", rif.rpt_id, 0);
    ready = 1'b1;
    repeat (12) drive(1'b0, '0);
    chk("t3_log_n", log_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < log_q.size()) chk("t3_order", log_q[i], i);
    end
    chk("t3_hold_end", hold, 0);

    // Overflow on a protocol violation, then clear; set wins over clear
    do_reset();
    ready = 1'b1;
    drive(1'b1, NR'(1) << 0);
    drive(1'b1, NR'(1) << 3);
    chk("t4_hold", hold, 1);
    drive(1'b0, '0);
    chk("t4_ovf_set", overflow, 1);
    chk("t4_sym_cnt", sym_cnt, 2);
    repeat (3) drive(1'b0, '0);
    chk("t4_log_n", log_q.size(), 1);
    if (log_q.size() == 1) chk("t4_log0", log_q[0], 0);
    clr_overflow = 1'b1;
    drive(1'b0, '0);
    clr_overflow = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    drive(1'b1, NR'(1) << 1);
    drive(1'b1, NR'(1) << 2);
    clr_overflow = 1'b1;
    drive(1'b0, '0);
    clr_overflow = 1'b0;
    chk("t4_set_wins", overflow, 1);
    repeat (3) drive(1'b0, '0);

    // Stamp wrap on the 4-bit counter instance
    do_reset();
    repeat (16) drive(1'b1, '0);
    drive(1'b1, NR'(1) << 2);
    drive(1'b0, '0);
    drive(1'b0, '0);
    chk("t5_w_valid", wif.rpt_valid, 1);
    chk("t5_w_id", wif.rpt_id, 2);
    chk("t5_w_cycle", wif.rpt_cycle, 0);
    chk("t5_w_sym_cnt", cnt_w, 1);
    chk("t5_cycle_wide", rif.rpt_cycle, 16);
    ready = 1'b1;
    drive(1'b0, '0);

    // Reset during the second drain cycle of a 4-bit batch
    do_reset();
    ready = 1'b1;
    drive(1'b1, (NR'(1) << 1) | (NR'(1) << 2) | (NR'(1) << 5) | (NR'(1) << 7));
    drive(1'b0, '0);
    drive(1'b0, '0);
    reset = 1'b1;
    drive(1'b0, '0);
    chk("t6_valid", rif.rpt_valid, 0);
    chk("t6_hold", hold, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_sym_cnt", sym_cnt, 0);
    reset = 1'b0;
    log_q.delete();
    repeat (6) drive(1'b0, '0);
    chk("t6_no_stale", log_q.size(), 0);
    chk("t6_valid_after", rif.rpt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
